// File: rtl/uart_pkg.sv
// Shared UART definitions: default rates, frame geometry and transmitter state encoding.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT  = 100_000_000;
  localparam int unsigned BAUD_RATE_DEFAULT = 9_600;
  localparam int unsigned FRAME_BITS        = 10;
  localparam int unsigned DATA_BITS         = FRAME_BITS - 2;

  typedef logic [DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter holding buffer.
interface uart_tx_if;

  logic                  tx_valid;
  uart_pkg::uart_byte_t  tx_data;
  logic                  tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter: bit_done is high on the last clock of every div_bit-clock period.
module uart_baud_gen #(
  parameter int unsigned div_bit = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned CNT_W = (div_bit > 1) ? $clog2(div_bit) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(div_bit - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Wrap to 0 at the end of each period so every state entry starts a fresh count
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (restart || (cnt == LAST)) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      bit_done <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      bit_done <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer for back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = CLK_FREQ_DEFAULT,
  parameter int unsigned baud_rate = BAUD_RATE_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     TxD,
  output logic     tx_busy
);

  localparam int unsigned DIV_BIT = clk_freq / baud_rate;
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);

  uart_state_e      state;
  uart_byte_t       shift;
  uart_byte_t       hold_data;
  logic             hold_full;
  logic [IDX_W-1:0] bit_idx;
  logic             bit_done;
  logic             restart;
  logic             accept;
  logic             consume;

  assign restart     = (state == ST_IDLE);
  assign accept      = bus.tx_valid && !hold_full;
  assign consume     = hold_full && ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));
  assign bus.tx_ready = !hold_full;

  uart_baud_gen #(.div_bit(DIV_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .bit_done (bit_done)
  );

  // Holding buffer; accept and consume are mutually exclusive since consume needs a full buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= bus.tx_data;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  // Frame sequencer; TxD is the registered line level of the state held during the previous clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      TxD     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          TxD <= 1'b1;
          if (hold_full) begin
            shift   <= hold_data;
            state   <= ST_START;
            tx_busy <= 1'b1;
          end
        end
        ST_START: begin
          TxD <= 1'b0;
          if (bit_done) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          TxD <= shift[0];
          if (bit_done) begin
            shift <= shift >> 1;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        ST_STOP: begin
          TxD <= 1'b1;
          if (bit_done) begin
            if (hold_full) begin
              shift <= hold_data;
              state <= ST_START;
            end else begin
              state   <= ST_IDLE;
              tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          TxD     <= 1'b1;
          state   <= ST_IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-timeline reference model, line decoder and directed/random traffic.
module tb_uart_tx;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int D     = 10;
  localparam int LIMIT = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic txd;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int a5_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  uart_tx_if bus();

  uart_tx #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .bus     (bus),
    .TxD     (txd),
    .tx_busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Reference model: a frame starting at edge S drives bit floor((e-S)/D) of start,data,stop
  bit         m_hold_full = 1'b0;
  logic [7:0] m_hold      = 8'h00;
  bit         m_active    = 1'b0;
  int         m_start     = 0;
  logic [7:0] m_byte      = 8'h00;
  int         m_e         = 0;
  bit         m_level     = 1'b1;
  bit         m_txd       = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    int k;
    if (!rst_n) begin
      m_hold_full = 1'b0;
      m_active    = 1'b0;
      m_e         = 0;
      m_level     = 1'b1;
      m_txd       = 1'b1;
    end else begin
      m_e++;
      acc   = bus.tx_valid && !m_hold_full;
      m_txd = m_level;
      if (m_active && (m_e - m_start == 10 * D)) begin
        if (m_hold_full) begin
          m_start     = m_e;
          m_byte      = m_hold;
          m_hold_full = 1'b0;
        end else begin
          m_active = 1'b0;
        end
      end else if (!m_active && m_hold_full) begin
        m_active    = 1'b1;
        m_start     = m_e;
        m_byte      = m_hold;
        m_hold_full = 1'b0;
      end
      if (acc) begin
        m_hold_full = 1'b1;
        m_hold      = bus.tx_data;
      end
      if (!m_active) begin
        m_level = 1'b1;
      end else begin
        k = (m_e - m_start) / D;
        if (k == 0)      m_level = 1'b0;
        else if (k <= 8) m_level = m_byte[k-1];
        else             m_level = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("txd", int'(txd), int'(m_txd));
      check("tx_busy", int'(busy), int'(m_active));
      check("tx_ready", int'(bus.tx_ready), int'(!m_hold_full));
    end
  end

  // Line decoder samples mid-bit and collects received bytes
  bit         d_busy = 1'b0;
  int         d_t    = 0;
  logic [7:0] d_byte = 8'h00;

  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      d_busy = 1'b0;
    end else if (!d_busy) begin
      if (txd == 1'b0) begin
        d_busy = 1'b1;
        d_t    = 0;
      end
    end else begin
      d_t++;
      if (d_t % D == D / 2) begin
        k = d_t / D;
        if (k == 0) begin
          check("rx_start_bit", int'(txd), 0);
        end else if (k <= 8) begin
          d_byte[k-1] = txd;
        end else begin
          check("rx_stop_bit", int'(txd), 1);
          rx_q.push_back(d_byte);
          d_busy = 1'b0;
        end
      end
    end
  end

  // All driver tasks are entered and left at a falling clock edge
  task automatic send(input logic [7:0] b, input bit keep, output int acc);
    int n;
    n            = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    while (!bus.tx_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", (n < LIMIT) ? 1 : 0, 1);
    @(negedge clk);
    acc = cyc;
    exp_q.push_back(b);
    if (!keep) bus.tx_valid = 1'b0;
  endtask

  task automatic wait_fall(output int fc);
    int n;
    n = 0;
    while (txd !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    while (txd !== 1'b0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("fall_wait", (n < LIMIT) ? 1 : 0, 1);
    fc = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic compare_queues(input string tag);
    int n;
    check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_rx_byte"}, int'(rx_q[i]), int'(exp_q[i]));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int acc, f, f2, bcnt, bad, idx, gap;
    bit keep;
    logic [7:0] b;

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("reset_txd", int'(txd), 1);
    check("reset_ready", int'(bus.tx_ready), 1);
    check("reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame: latency, bit pattern, busy length
    send(8'hA5, 1'b0, acc);
    f    = -1;
    bcnt = 0;
    while (cyc <= acc + 150) begin
      if (busy) bcnt++;
      if (f < 0 && txd == 1'b0) f = cyc;
      if (f >= 0 && (cyc - f) < 10 * D && (cyc - f) % D == D / 2) begin
        idx = (cyc - f) / D;
        check("a5_bit", int'(txd), a5_seq[idx]);
      end
      @(negedge clk);
    end
    check("a5_latency", f - acc, 2);
    check("a5_busy_clocks", bcnt, 100);
    compare_queues("single");

    // Back-to-back 0x00 then 0xFF, second offered during DATA
    send(8'h00, 1'b0, acc);
    wait_fall(f);
    wait_until(f + 30);
    send(8'hFF, 1'b0, acc);
    bad = 0;
    while (cyc < f + 99) begin
      if (bus.tx_ready) bad++;
      @(negedge clk);
    end
    check("b2b_ready_low", bad, 0);
    check("b2b_ready_back", int'(bus.tx_ready), 1);
    wait_fall(f2);
    check("b2b_gap", f2 - f, 100);
    wait_until(cyc + 150);
    compare_queues("b2b");

    // Backpressure: tx_valid held high across three distinct bytes
    send(8'h5A, 1'b1, acc);
    send(8'hC3, 1'b1, acc);
    send(8'h81, 1'b0, acc);
    wait_until(cyc + 350);
    compare_queues("backpressure");

    // Late accept on the last STOP clock
    send(8'h11, 1'b0, acc);
    wait_fall(f);
    wait_until(f + 98);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h3C;
    check("late_ready", int'(bus.tx_ready), 1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    exp_q.push_back(8'h3C);
    check("late_idle_busy", int'(busy), 0);
    @(negedge clk);
    check("late_idle_line", int'(txd), 1);
    wait_fall(f2);
    check("late_gap", f2 - f, 101);
    wait_until(cyc + 150);
    compare_queues("late");

    // Reset during DATA bit 4 with a byte buffered
    send(8'h96, 1'b0, acc);
    wait_fall(f);
    send(8'h42, 1'b0, acc);
    check("rst_buffered", int'(bus.tx_ready), 0);
    wait_until(f - 1 + 55);
    #2 rst_n = 1'b0;
    #1;
    check("rst_txd", int'(txd), 1);
    check("rst_ready", int'(bus.tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    exp_q.delete();
    rx_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    wait_until(cyc + 300);
    check("rst_no_frame", rx_q.size(), 0);

    // Idle line for 1000 clocks
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_line", bad, 0);

    // Random bytes, gaps and held-valid bursts
    for (int i = 0; i < 25; i++) begin
      b    = 8'($urandom_range(0, 255));
      keep = ($urandom_range(0, 3) == 0) && (i != 24);
      send(b, keep, acc);
      if (!keep) begin
        gap = $urandom_range(0, 130);
        repeat (gap) @(negedge clk);
      end
    end
    wait_until(cyc + 400);
    compare_queues("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
